// File: rtl/branch_predictor_param_if.sv
// Fetch-side lookup, BTB install and BHT training signals of the next-PC predictor.
// The master drives PCs and updates; the slave (predictor) returns the prediction.
interface branch_predictor_param_if #(
  parameter int WORD_W = 16
) ();
  logic [WORD_W-1:0] pc;
  logic              btb_wr_en;
  logic [WORD_W-1:0] btb_wr_pc;
  logic [WORD_W-1:0] btb_wr_target;
  logic              bht_upd_en;
  logic [WORD_W-1:0] bht_upd_pc;
  logic              bht_upd_taken;
  logic              tag_match;
  logic              predict_taken;
  logic [WORD_W-1:0] predicted_pc;

  modport master (
    output pc, btb_wr_en, btb_wr_pc, btb_wr_target,
    output bht_upd_en, bht_upd_pc, bht_upd_taken,
    input  tag_match, predict_taken, predicted_pc
  );

  modport slave (
    input  pc, btb_wr_en, btb_wr_pc, btb_wr_target,
    input  bht_upd_en, bht_upd_pc, bht_upd_taken,
    output tag_match, predict_taken, predicted_pc
  );
endinterface

// File: rtl/branch_predictor_param.sv
// Parametrised BTB + 2-bit BHT next-PC predictor with zero-latency lookup.
// Optional BP_GSHARE_EN: tagless counters indexed by PC index XOR global history.
module branch_predictor_param #(
  parameter int         WORD_W   = 16,
  parameter int         IDX_W    = 8,
  parameter int         MODE     = 2,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input logic                     clk,
  input logic                     reset_n,
  branch_predictor_param_if.slave bp
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = WORD_W - IDX_W;
  localparam bit HAS_CNT = (MODE >= 2);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [TAG_W-1:0]  tag_d    [DEPTH];
  logic [WORD_W-1:0] target_q [DEPTH];
  logic [WORD_W-1:0] target_d [DEPTH];
  logic [1:0]        cnt_q    [DEPTH];
  logic [1:0]        cnt_d    [DEPTH];

  logic [IDX_W-1:0]  lk_idx, lk_cidx, wr_idx, upd_idx, upd_cidx;
  logic [TAG_W-1:0]  lk_tag, wr_tag, upd_tag;
  logic              lk_hit, lk_taken, wr_replace;
  logic              same_idx, eff_valid, upd_hit;
  logic [TAG_W-1:0]  eff_tag;
  logic [1:0]        eff_cnt;

  // Saturating 2-bit counter step; MODE 3 jumps across the weak states.
  function automatic logic [1:0] train_cnt(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (MODE == 3 && cnt == 2'b01) begin
        res = 2'b11;
      end else if (cnt != 2'b11) begin
        res = cnt + 2'b01;
      end else begin
        res = cnt;
      end
    end else begin
      if (MODE == 3 && cnt == 2'b10) begin
        res = 2'b00;
      end else if (cnt != 2'b00) begin
        res = cnt - 2'b01;
      end else begin
        res = cnt;
      end
    end
    return res;
  endfunction

  assign lk_idx  = bp.pc[IDX_W-1:0];
  assign lk_tag  = bp.pc[WORD_W-1:IDX_W];
  assign wr_idx  = bp.btb_wr_pc[IDX_W-1:0];
  assign wr_tag  = bp.btb_wr_pc[WORD_W-1:IDX_W];
  assign upd_idx = bp.bht_upd_pc[IDX_W-1:0];
  assign upd_tag = bp.bht_upd_pc[WORD_W-1:IDX_W];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  assign lk_cidx  = lk_idx ^ ghr_q;
  assign upd_cidx = upd_idx ^ ghr_q;

  // Global history shifts in every resolved outcome.
  always_comb begin
    if (bp.bht_upd_en) begin
      ghr_d = {ghr_q[IDX_W-2:0], bp.bht_upd_taken};
    end else begin
      ghr_d = ghr_q;
    end
  end

  // History register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= {IDX_W{1'b0}};
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign lk_cidx  = lk_idx;
  assign upd_cidx = upd_idx;
`endif

  // Lookup reads only registered state, so a same-cycle write is not bypassed.
  always_comb begin
    lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    case (MODE)
      0:       lk_taken = 1'b0;
      1:       lk_taken = lk_hit;
      2, 3:    lk_taken = lk_hit && cnt_q[lk_cidx][1];
      default: lk_taken = 1'b0;
    endcase
  end

  assign bp.tag_match     = lk_hit;
  assign bp.predict_taken = lk_taken;
  assign bp.predicted_pc  = lk_taken ? target_q[lk_idx]
                                     : bp.pc + {{(WORD_W-1){1'b0}}, 1'b1};

  // Training sees the entry as it will be after this cycle's install.
  assign wr_replace = !valid_q[wr_idx] || (tag_q[wr_idx] != wr_tag);
  assign same_idx   = bp.btb_wr_en && (wr_idx == upd_idx);
  assign eff_valid  = same_idx ? 1'b1 : valid_q[upd_idx];
  assign eff_tag    = same_idx ? wr_tag : tag_q[upd_idx];
`ifdef BP_GSHARE_EN
  assign eff_cnt    = cnt_q[upd_cidx];
  assign upd_hit    = 1'b1;
`else
  assign eff_cnt    = (same_idx && wr_replace) ? CNT_INIT : cnt_q[upd_idx];
  assign upd_hit    = eff_valid && (eff_tag == upd_tag);
`endif

  // Next-state for the BTB entries and counters.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (bp.btb_wr_en) begin
      valid_d[wr_idx]  = 1'b1;
      tag_d[wr_idx]    = wr_tag;
      target_d[wr_idx] = bp.btb_wr_target;
`ifndef BP_GSHARE_EN
      if (wr_replace) begin
        cnt_d[wr_idx] = CNT_INIT;
      end else begin
        cnt_d[wr_idx] = cnt_q[wr_idx];
      end
`endif
    end else begin
      valid_d[wr_idx] = valid_q[wr_idx];
    end
    // Gshare counters are shared across branches, so installs leave them alone.
    if (HAS_CNT && bp.bht_upd_en && upd_hit) begin
      cnt_d[upd_cidx] = train_cnt(eff_cnt, bp.bht_upd_taken);
    end else begin
      cnt_d[upd_cidx] = cnt_d[upd_cidx];
    end
  end

  // Table state; reset clears every entry and drops any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]    <= {TAG_W{1'b0}};
        target_q[i] <= {WORD_W{1'b0}};
        cnt_q[i]    <= CNT_INIT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
